// File: rtl/pipe_hazard_ctrl.sv
// Y86-64 pipeline control: stall/bubble generation, condition codes,
// RUN/DRAIN/HALT exception sequencing and performance counters.
module pipe_hazard_ctrl #(
   parameter int         CNT_W = 32,
   parameter logic [3:0] RNONE = 4'hF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [3:0]       D_icode,
   input  logic [3:0]       d_srcA,
   input  logic [3:0]       d_srcB,
   input  logic [3:0]       E_icode,
   input  logic [3:0]       E_dstM,
   input  logic             e_cnd,
   input  logic [3:0]       M_icode,
   input  logic [2:0]       m_stat,
   input  logic [2:0]       W_stat,
   input  logic [2:0]       alu_cf,
   output logic             F_stall,
   output logic             D_stall,
   output logic             D_bubble,
   output logic             E_bubble,
   output logic             M_bubble,
   output logic             W_stall,
   output logic [2:0]       cc,
   output logic             halted,
   output logic [2:0]       halt_stat,
   output logic [CNT_W-1:0] cycle_cnt,
   output logic [CNT_W-1:0] retire_cnt
);

   localparam logic [2:0] SAOK = 3'd1;
   localparam logic [2:0] SHLT = 3'd2;
   localparam logic [2:0] SADR = 3'd3;
   localparam logic [2:0] SINS = 3'd4;

   localparam logic [3:0] I_MRMOV = 4'h5;
   localparam logic [3:0] I_OPQ   = 4'h6;
   localparam logic [3:0] I_JXX   = 4'h7;
   localparam logic [3:0] I_RET   = 4'h9;
   localparam logic [3:0] I_POPQ  = 4'hB;

   typedef enum logic [1:0] {
      RUN,
      DRAIN,
      HALT
   } state_t;

   state_t state;

   function automatic logic is_exc(input logic [2:0] s);
      return (s == SHLT) || (s == SADR) || (s == SINS);
   endfunction

   logic lu;
   logic mis;
   logic rt;
   logic exc_m;
   logic exc_w;
   logic set_cc;

   always_comb begin
      exc_m  = is_exc(m_stat);
      exc_w  = is_exc(W_stat);
      lu     = ((E_icode == I_MRMOV) || (E_icode == I_POPQ)) &&
               (E_dstM != RNONE) &&
               ((E_dstM == d_srcA) || (E_dstM == d_srcB));
      mis    = (E_icode == I_JXX) && !e_cnd;
      rt     = (D_icode == I_RET) || (E_icode == I_RET) ||
               (M_icode == I_RET);
      set_cc = (E_icode == I_OPQ) && !exc_m && !exc_w &&
               (state != HALT);
   end

   // Reset overrides everything so the pipe flushes to nops.
   always_comb begin
      F_stall  = 1'b0;
      D_stall  = 1'b0;
      D_bubble = 1'b1;
      E_bubble = 1'b1;
      M_bubble = 1'b1;
      W_stall  = 1'b0;
      if (reset) begin
         F_stall  = 1'b0;
      end else if (state == HALT) begin
         F_stall  = 1'b1;
         D_stall  = 1'b1;
         D_bubble = 1'b0;
         W_stall  = 1'b1;
      end else begin
         F_stall  = lu | rt;
         D_stall  = lu;
         D_bubble = mis | (rt & !lu);
         E_bubble = mis | lu;
         M_bubble = exc_m | exc_w;
         W_stall  = exc_w;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= RUN;
         cc         <= 3'b100;
         halt_stat  <= 3'd0;
         cycle_cnt  <= '0;
         retire_cnt <= '0;
      end else begin
         if (state != HALT) begin
            cycle_cnt <= cycle_cnt + CNT_W'(1);
            if (W_stat == SAOK)
               retire_cnt <= retire_cnt + CNT_W'(1);
         end
         if (set_cc)
            cc <= alu_cf;
         unique case (state)
            RUN: begin
               if (exc_w) begin
                  state     <= HALT;
                  halt_stat <= W_stat;
               end else if (exc_m) begin
                  state <= DRAIN;
               end
            end
            DRAIN: begin
               if (exc_w) begin
                  state     <= HALT;
                  halt_stat <= W_stat;
               end
            end
            HALT: state <= HALT;
            default: state <= RUN;
         endcase
      end
   end

   assign halted = (state == HALT);

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Randomized bench for pipe_hazard_ctrl against a rule-level model,
// plus directed literal checks and a narrow-counter wrap instance.
module tb_pipe_hazard_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] D_icode, d_srcA, d_srcB, E_icode, E_dstM, M_icode;
   logic       e_cnd;
   logic [2:0] m_stat, W_stat, alu_cf;

   logic        F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall;
   logic [2:0]  cc, halt_stat;
   logic        halted;
   logic [31:0] cycle_cnt, retire_cnt;

   logic        f4, d4, db4, eb4, mb4, w4, h4;
   logic [2:0]  cc4, hs4;
   logic [3:0]  cyc4, ret4;

   int n_chk = 0;
   int n_err = 0;
   bit chk_en = 1'b0;

   // reference state
   bit          m_halt;
   logic [2:0]  m_cc, m_hs;
   logic [31:0] m_cyc, m_ret;

   always #5 clk = ~clk;

   pipe_hazard_ctrl dut (
      .clk(clk), .reset(reset),
      .D_icode(D_icode), .d_srcA(d_srcA), .d_srcB(d_srcB),
      .E_icode(E_icode), .E_dstM(E_dstM), .e_cnd(e_cnd),
      .M_icode(M_icode), .m_stat(m_stat), .W_stat(W_stat),
      .alu_cf(alu_cf),
      .F_stall(F_stall), .D_stall(D_stall), .D_bubble(D_bubble),
      .E_bubble(E_bubble), .M_bubble(M_bubble), .W_stall(W_stall),
      .cc(cc), .halted(halted), .halt_stat(halt_stat),
      .cycle_cnt(cycle_cnt), .retire_cnt(retire_cnt)
   );

   pipe_hazard_ctrl #(.CNT_W(4)) dut4 (
      .clk(clk), .reset(reset),
      .D_icode(D_icode), .d_srcA(d_srcA), .d_srcB(d_srcB),
      .E_icode(E_icode), .E_dstM(E_dstM), .e_cnd(e_cnd),
      .M_icode(M_icode), .m_stat(m_stat), .W_stat(W_stat),
      .alu_cf(alu_cf),
      .F_stall(f4), .D_stall(d4), .D_bubble(db4),
      .E_bubble(eb4), .M_bubble(mb4), .W_stall(w4),
      .cc(cc4), .halted(h4), .halt_stat(hs4),
      .cycle_cnt(cyc4), .retire_cnt(ret4)
   );

   function automatic bit exc(input logic [2:0] s);
      return (s == 3'd2) || (s == 3'd3) || (s == 3'd4);
   endfunction

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp,
                  $time);
      end
   endtask

   always @(posedge clk) begin
      if (reset) begin
         m_halt <= 1'b0;
         m_cc   <= 3'b100;
         m_hs   <= 3'd0;
         m_cyc  <= 32'd0;
         m_ret  <= 32'd0;
      end else if (!m_halt) begin
         m_cyc <= m_cyc + 32'd1;
         if (W_stat == 3'd1) m_ret <= m_ret + 32'd1;
         if (E_icode == 4'h6 && !exc(m_stat) && !exc(W_stat))
            m_cc <= alu_cf;
         if (exc(W_stat)) begin
            m_halt <= 1'b1;
            m_hs   <= W_stat;
         end
      end
   end

   always @(negedge clk) begin : cmp
      bit lu, mis, rt;
      logic [5:0] exp_o, act_o;
      if (chk_en) begin
         lu  = (E_icode == 4'h5 || E_icode == 4'hB) && E_dstM != 4'hF &&
               (E_dstM == d_srcA || E_dstM == d_srcB);
         mis = E_icode == 4'h7 && !e_cnd;
         rt  = D_icode == 4'h9 || E_icode == 4'h9 || M_icode == 4'h9;
         if (reset)
            exp_o = 6'b001110;
         else if (m_halt)
            exp_o = 6'b110111;
         else
            exp_o = {lu | rt, lu, mis | (rt & !lu), mis | lu,
                     exc(m_stat) | exc(W_stat), exc(W_stat)};
         act_o = {F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall};
         chk("ctrl", 32'(act_o), 32'(exp_o));
         chk("ctrl4", 32'({f4, d4, db4, eb4, mb4, w4}), 32'(exp_o));
         chk("cc", 32'(cc), 32'(m_cc));
         chk("halted", 32'(halted), 32'(m_halt));
         chk("halt_stat", 32'(halt_stat), 32'(m_hs));
         chk("cycle_cnt", cycle_cnt, m_cyc);
         chk("retire_cnt", retire_cnt, m_ret);
         chk("cycle_cnt4", 32'(cyc4), 32'(m_cyc[3:0]));
         chk("retire_cnt4", 32'(ret4), 32'(m_ret[3:0]));
      end
   end

   task automatic idle();
      D_icode = 4'h1; E_icode = 4'h1; M_icode = 4'h1;
      d_srcA = 4'hF; d_srcB = 4'hF; E_dstM = 4'hF;
      e_cnd = 1'b1; m_stat = 3'd1; W_stat = 3'd1; alu_cf = 3'd0;
   endtask

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   initial begin
      idle();
      reset = 1'b1;
      nxt();
      nxt();
      chk_en = 1'b1;
      reset = 1'b0;
      repeat (5) nxt();
      @(negedge clk);
      chk("rst_cc", 32'(cc), 32'h4);
      chk("rst_cyc", cycle_cnt, 32'd5);
      chk("rst_ret", retire_cnt, 32'd5);
      chk("rst_ctrl", 32'({F_stall, D_stall, D_bubble, E_bubble,
                           M_bubble, W_stall}), 32'd0);

      nxt();
      E_icode = 4'h5; E_dstM = 4'h3; d_srcB = 4'h3;
      @(negedge clk);
      chk("lu", 32'({F_stall, D_stall, D_bubble, E_bubble}), 32'hD);
      nxt();
      E_dstM = 4'hF; d_srcA = 4'hF;
      @(negedge clk);
      chk("lu_rnone", 32'({F_stall, D_stall, D_bubble, E_bubble}), 32'h0);

      nxt(); idle();
      E_icode = 4'h7; e_cnd = 1'b0;
      @(negedge clk);
      chk("mis", 32'({F_stall, D_bubble, E_bubble}), 32'h3);
      nxt();
      e_cnd = 1'b1;
      @(negedge clk);
      chk("taken", 32'({F_stall, D_bubble, E_bubble}), 32'h0);
      nxt(); idle();
      D_icode = 4'h9;
      @(negedge clk);
      chk("ret", 32'({F_stall, D_bubble, E_bubble}), 32'h6);

      nxt(); idle();
      E_icode = 4'h6; alu_cf = 3'b011;
      nxt(); idle();
      @(negedge clk);
      chk("cc_set", 32'(cc), 32'h3);
      E_icode = 4'h6; m_stat = 3'd3; alu_cf = 3'b100;
      @(negedge clk);
      chk("exc_mbub", 32'(M_bubble), 32'h1);
      nxt(); idle();
      @(negedge clk);
      chk("cc_hold", 32'(cc), 32'h3);

      reset = 1'b1;
      nxt();
      reset = 1'b0;
      m_stat = 3'd2;
      nxt();
      m_stat = 3'd1; W_stat = 3'd2;
      @(negedge clk);
      chk("drain_nh", 32'(halted), 32'h0);
      nxt();
      W_stat = 3'd1;
      @(negedge clk);
      chk("halt", 32'(halted), 32'h1);
      chk("halt_stat", 32'(halt_stat), 32'h2);
      chk("halt_cyc", cycle_cnt, 32'd2);
      chk("halt_ret", retire_cnt, 32'd1);
      repeat (10) nxt();
      @(negedge clk);
      chk("frz_cyc", cycle_cnt, 32'd2);
      chk("frz_ret", retire_cnt, 32'd1);
      chk("frz_fw", 32'({F_stall, W_stall}), 32'h3);
      reset = 1'b1;
      @(negedge clk);
      chk("rst_comb", 32'({F_stall, D_bubble}), 32'h1);
      nxt();
      @(negedge clk);
      chk("rst_halt", 32'(halted), 32'h0);
      chk("rst_cyc0", cycle_cnt, 32'd0);
      reset = 1'b0;

      repeat (17) nxt();
      @(negedge clk);
      chk("wrap_cyc4", 32'(cyc4), 32'd1);
      chk("wrap_ret4", 32'(ret4), 32'd1);
      chk("wrap_cyc", cycle_cnt, 32'd17);

      for (int i = 0; i < 600; i++) begin
         nxt();
         reset   = ($urandom_range(0, 29) == 0);
         D_icode = 4'($urandom);
         E_icode = 4'($urandom);
         M_icode = 4'($urandom);
         if ($urandom_range(0, 2) == 0) E_icode = 4'h5;
         E_dstM  = ($urandom_range(0, 3) == 0) ? 4'hF :
                   4'($urandom_range(0, 3));
         d_srcA  = ($urandom_range(0, 3) == 0) ? 4'hF :
                   4'($urandom_range(0, 3));
         d_srcB  = ($urandom_range(0, 3) == 0) ? 4'hF :
                   4'($urandom_range(0, 3));
         e_cnd   = 1'($urandom);
         alu_cf  = 3'($urandom);
         m_stat  = ($urandom_range(0, 19) == 0) ?
                   3'($urandom_range(2, 4)) : 3'($urandom_range(0, 1));
         W_stat  = ($urandom_range(0, 29) == 0) ?
                   3'($urandom_range(2, 4)) : 3'($urandom_range(0, 1));
      end
      @(negedge clk);
      #1;
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Pipeline control unit for the Y86-64 five-stage pipe.
- Generates per-stage stall/bubble controls for load-use, mispredicted jXX and ret hazards.
- Owns the condition-code register (ZF/SF/OF) fed from the execute-stage ALU flags and decides when it may be written.
- Runs a RUN/DRAIN/HALT state machine on exception status, and keeps cycle and retired-instruction counters.

Parameters:
- CNT_W, 32, width of cycle_cnt and retire_cnt.
- RNONE, 4'hF, register ID meaning "no register".

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- D_icode  input  4  icode in decode stage.
- d_srcA  input  4  decode srcA register ID.
- d_srcB  input  4  decode srcB register ID.
- E_icode  input  4  icode in execute stage.
- E_dstM  input  4  execute-stage dstM register ID.
- e_cnd  input  1  branch/cmov condition computed in execute.
- M_icode  input  4  icode in memory stage.
- m_stat  input  3  memory-stage status after data-memory access.
- W_stat  input  3  writeback-stage status.
- alu_cf  input  3  ALU flags {ZF,SF,OF} from the execute ALU.
- F_stall  output  1  hold F register.
- D_stall  output  1  hold D register.
- D_bubble  output  1  load nop into D.
- E_bubble  output  1  load nop into E.
- M_bubble  output  1  load nop into M.
- W_stall  output  1  hold W register.
- cc  output  3  registered {ZF,SF,OF} to the condition evaluator.
- halted  output  1  state==HALT.
- halt_stat  output  3  W_stat captured on HALT entry.
- cycle_cnt  output  CNT_W  cycles spent in RUN or DRAIN.
- retire_cnt  output  CNT_W  retired instructions.

Behaviour:
- Encodings:
  - stat: SBUB=0, SAOK=1, SHLT=2, SADR=3, SINS=4.
  - icode: OPq=6, jXX=7, ret=9, mrmovq=5, popq=B.
  - exc(x) = x is SHLT, SADR or SINS.
- Combinational hazard terms:
  - lu = (E_icode in {5,B}) && E_dstM!=RNONE && (E_dstM==d_srcA || E_dstM==d_srcB).
  - mis = E_icode==7 && !e_cnd.
  - rt = 9 in {D_icode, E_icode, M_icode}.
- Outputs in RUN and DRAIN:
  - F_stall = lu | rt.
  - D_stall = lu.
  - D_bubble = mis | (rt & !lu).
  - E_bubble = mis | lu.
  - M_bubble = exc(m_stat) | exc(W_stat).
  - W_stall = exc(W_stat).
- HALT state outputs: F_stall=D_stall=W_stall=1, E_bubble=M_bubble=1, D_bubble=0.
- Whenever reset=1, outputs are F_stall=D_stall=W_stall=0 and D_bubble=E_bubble=M_bubble=1, regardless of state.
- set_cc = (E_icode==6) && !exc(m_stat) && !exc(W_stat) && state!=HALT.
- cc register:
  - On a clk edge with set_cc, cc <= alu_cf.
  - Otherwise cc holds.
  - Reset value 3'b100 (ZF=1).
  - Result is visible the cycle after the OPq leaves E.
- FSM, registered, evaluated at the clk edge:
  - RUN: exc(m_stat) && !exc(W_stat) -> DRAIN; exc(W_stat) -> HALT (takes priority).
  - DRAIN: exc(W_stat) -> HALT; otherwise stay in DRAIN. DRAIN never returns to RUN.
  - HALT: terminal until reset.
  - On HALT entry, halt_stat <= W_stat. halt_stat holds in HALT and is 0 otherwise.
- Counters:
  - cycle_cnt increments every clk while state!=HALT.
  - retire_cnt increments when W_stat==SAOK and state!=HALT.
  - Both wrap modulo 2^CNT_W and freeze in HALT.
  - The cycle in which the HALT transition is taken still counts.
- Reset: state=RUN, cc=3'b100, halted=0, halt_stat=0, both counters 0. Reset mid-DRAIN or in HALT returns to RUN on the next edge.
- Simultaneous events:
  - lu with rt in D: F_stall=1, D_stall=1, D_bubble=0, E_bubble=1.
  - mis with rt in D: D_bubble=1, E_bubble=1, F_stall=1.
  - Exception in M plus OPq in E: cc is not written.
- E_dstM==RNONE never produces lu, even when d_srcA/d_srcB==RNONE.

Test Plan:
- Reset then 5 idle cycles with W_stat=SAOK -> cc=3'b100, cycle_cnt=5, retire_cnt=5, all stalls/bubbles 0.
- E_icode=5, E_dstM=3, d_srcB=3 -> F_stall=1, D_stall=1, E_bubble=1, D_bubble=0. Same with E_dstM=F, d_srcA=F -> all 0.
- E_icode=7, e_cnd=0 -> D_bubble=1, E_bubble=1, F_stall=0. With e_cnd=1 -> all 0. D_icode=9 alone -> F_stall=1, D_bubble=1.
- E_icode=6, alu_cf=3'b011, m_stat=SAOK -> cc=3'b011 next cycle. Repeat with m_stat=SADR, alu_cf=3'b100 -> cc stays 3'b011 and M_bubble=1.
- m_stat=SHLT for one cycle, next cycle W_stat=SHLT:
  - State goes RUN->DRAIN->HALT; halted=1, halt_stat=2.
  - Counters frozen over 10 more cycles; F_stall=W_stall=1.
  - Assert reset -> halted=0, cycle_cnt=0.
- CNT_W=4, run 17 AOK cycles from reset -> cycle_cnt=1, retire_cnt=1 (wrap).
